data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 16 +
 rtl/mem_latency_timer.sv | 32 +++
 rtl/data_memory.sv | 103 ++++++++++
 tb/tb_data_memory.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and state type for the data_memory slice
package data_memory_pkg;

    localparam int DEF_LINE_W  = 256;
    localparam int DEF_DEPTH   = 512;
    localparam int DEF_LATENCY = 10;
    localparam int IDX_W       = 9;
    localparam int OFFSET_W    = 5;
    localparam int CNT_W       = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_latency_timer.sv
// rtl/mem_latency_timer.sv - fixed-latency countdown that decodes the ack cycle
module mem_latency_timer
    import data_memory_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic active_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt;

    // Restart at zero on acceptance, then count every cycle while a request is outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (start_i) begin
            cnt <= '0;
        end else if (active_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Done is a pure decode of registered state so the ack never glitches on inputs
    assign done_o = active_i && (cnt == LAST);

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - line-wide main memory model with fixed latency; optional DATA_MEMORY_STATS_EN counters
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
`endif
);

    // Storage lives here so benches can reach it as memory[i]; it is never reset
    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t            state;
    logic [IDX_W-1:0]  req_addr;
    logic [LINE_W-1:0] req_data;
    logic              req_wr;

    logic [IDX_W-1:0]  cur_idx;
    logic              start;
    logic              unused_addr_bits;

    assign cur_idx          = addr_i[OFFSET_W +: IDX_W];
    assign unused_addr_bits = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};
    assign start            = (state == IDLE) && enable_i;

    mem_latency_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start),
        .active_i (state == WAIT),
        .done_o   (ack_o)
    );

    // Request FSM: latch on acceptance, ignore inputs while waiting, return to idle after the ack cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        req_addr <= cur_idx;
                        req_data <= data_i;
                        req_wr   <= write_i;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit a write at the edge closing the ack cycle; a coincident reset suppresses it
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_o && req_wr) begin
            memory[req_addr] <= req_data;
        end
    end

    // Idle reads follow the live address; once busy the latched line is shown (old data on a write)
    assign data_o = (state == IDLE) ? memory[cur_idx] : memory[req_addr];

`ifdef DATA_MEMORY_STATS_EN
    // Completed-transfer counters, bumped at the same edge a write would commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (ack_o) begin
            if (req_wr) begin
                wr_count_o <= wr_count_o + 32'd1;
            end else begin
                rd_count_o <= rd_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - randomized model-checked bench for data_memory
module tb_data_memory;

    localparam int LAT = 10;

    localparam logic [255:0] LINE0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] LINE1  = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [255:0] LINE2  = {16{16'hECFA}};
    localparam logic [255:0] LINE17 = 256'h0000_0110_0220_0330_0440_0550_0660_0770_0880_0990_0AA0_0BB0_0CC0_0DD0_0EE0_0FF0;
    localparam logic [255:0] WDATA  = 256'h1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F_0000;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;
`ifdef DATA_MEMORY_STATS_EN
    logic [31:0]  rd_count_o;
    logic [31:0]  wr_count_o;
`endif

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
`ifdef DATA_MEMORY_STATS_EN
        ,
        .rd_count_o (rd_count_o),
        .wr_count_o (wr_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding request completing LAT cycles after acceptance
    logic [255:0] mm [0:511];
    bit           pending = 0;
    int           due = 0;
    int           req_idx = 0;
    bit           req_wr = 0;
    logic [255:0] req_data = '0;
    int           edges = 0;
    int           rd_n = 0;
    int           wr_n = 0;

    always @(posedge clk_i) begin
        int idx;
        idx = edges;
        edges++;
        if (rst_i) begin
            pending = 0;
            rd_n = 0;
            wr_n = 0;
        end else if (pending) begin
            if (idx == due) begin
                if (req_wr) begin
                    mm[req_idx] = req_data;
                    wr_n++;
                end else begin
                    rd_n++;
                end
                pending = 0;
            end
        end else if (enable_i) begin
            pending  = 1;
            due      = idx + LAT;
            req_idx  = int'(addr_i[13:5]);
            req_wr   = write_i;
            req_data = data_i;
        end
    end

    // Compare DUT against the reference every cycle, mid-cycle
    always @(negedge clk_i) begin
        if (edges > 0) begin
            check("ack_o", {255'd0, ack_o}, {255'd0, (pending && edges == due)});
            if (pending)
                check("data_o_busy", data_o, mm[req_idx]);
            else
                check("data_o_idle", data_o, mm[int'(addr_i[13:5])]);
`ifdef DATA_MEMORY_STATS_EN
            check("rd_count_o", {224'd0, rd_count_o}, {224'd0, 32'(rd_n)});
            check("wr_count_o", {224'd0, wr_count_o}, {224'd0, 32'(wr_n)});
`endif
        end
    end

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic edge_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit en, input bit wr, input logic [31:0] a, input logic [255:0] d);
        enable_i = en;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
    endtask

    task automatic wait_ack(output int n, output logic [255:0] d);
        n = 0;
        d = '0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                n = i;
                d = data_o;
                break;
            end
        end
        if (n == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout actual=none required=ack within 300 cycles");
        end else begin
            edge_step();
        end
    endtask

    task automatic count_acks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (ack_o) n++;
        end
        edge_step();
    endtask

    initial begin
        int           n;
        logic [255:0] d;

        for (int i = 0; i < 512; i++) mm[i] = rnd_line();
        mm[0]  = LINE0;
        mm[1]  = LINE1;
        mm[2]  = LINE2;
        mm[17] = LINE17;
        for (int i = 0; i < 512; i++) dut.memory[i] = mm[i];

        rst_i = 1'b1;
        repeat (3) edge_step();
        rst_i = 1'b0;
        edge_step();
        check("reset_ack", {255'd0, ack_o}, 256'd0);

        // Read latency: ack in the 10th cycle after acceptance, carrying line 1
        drive(1, 0, 32'h20, '0);
        edge_step();
        drive(0, 0, 32'h0, '0);
        wait_ack(n, d);
        check("read_latency", 256'(n), 256'd10);
        check("read_data", d, LINE1);

        // Write with enable held: line 32 changes only after the ack edge
        drive(1, 1, 32'h400, WDATA);
        edge_step();
        check("write_before_ack", dut.memory[32], mm[32]);
        wait_ack(n, d);
        drive(0, 0, 32'h0, '0);
        check("write_latency", 256'(n), 256'd10);
        check("write_committed", dut.memory[32], WDATA);

        // Enable for one cycle, then the address moves: the latched line 2 is returned
        drive(1, 0, 32'h40, '0);
        edge_step();
        drive(0, 0, 32'h200, '0);
        wait_ack(n, d);
        check("drop_latency", 256'(n), 256'd10);
        check("drop_data", d, LINE2);

        // Reset mid-wait aborts the write
        drive(1, 1, 32'h220, rnd_line());
        edge_step();
        drive(0, 0, 32'h0, '0);
        repeat (4) edge_step();
        rst_i = 1'b1;
        edge_step();
        rst_i = 1'b0;
        count_acks(20, n);
        check("abort_no_ack", 256'(n), 256'd0);
        check("abort_line17", dut.memory[17], LINE17);
        drive(1, 0, 32'h220, '0);
        edge_step();
        drive(0, 0, 32'h0, '0);
        wait_ack(n, d);
        check("after_abort_latency", 256'(n), 256'd10);
        check("after_abort_data", d, LINE17);

        // Back-to-back with enable held, aliased address 0x4000 -> line 0
        drive(1, 0, 32'h4000, '0);
        edge_step();
        wait_ack(n, d);
        check("b2b_first_latency", 256'(n), 256'd10);
        check("alias_data", d, LINE0);
        wait_ack(n, d);
        drive(0, 0, 32'h0, '0);
        check("b2b_second_latency", 256'(n), 256'd11);
        check("alias_data2", d, LINE0);

        // Random traffic including dropped enables, mid-flight input churn and stray resets
        for (int c = 0; c < 2500; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, rnd_line());
            edge_step();
        end
        rst_i = 1'b0;
        drive(0, 0, 32'h0, '0);
        repeat (LAT + 2) edge_step();

`ifdef DATA_MEMORY_STATS_EN
        // One read and two writes, then reset clears both counters
        rst_i = 1'b1;
        edge_step();
        rst_i = 1'b0;
        drive(1, 0, 32'h20, '0);
        edge_step();
        drive(0, 0, 32'h0, '0);
        wait_ack(n, d);
        drive(1, 1, 32'h60, rnd_line());
        edge_step();
        drive(0, 0, 32'h0, '0);
        wait_ack(n, d);
        drive(1, 1, 32'h80, rnd_line());
        edge_step();
        drive(0, 0, 32'h0, '0);
        wait_ack(n, d);
        check("stats_rd", {224'd0, rd_count_o}, 256'd1);
        check("stats_wr", {224'd0, wr_count_o}, 256'd2);
        rst_i = 1'b1;
        edge_step();
        rst_i = 1'b0;
        check("stats_rd_reset", {224'd0, rd_count_o}, 256'd0);
        check("stats_wr_reset", {224'd0, wr_count_o}, 256'd0);
`endif

        for (int i = 0; i < 512; i++) check($sformatf("final_line_%0d", i), dut.memory[i], mm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
